// File: rtl/bus_responder_timer_if.sv
// CPU data-bus req/ack channel between an initiator (master) and a
// memory-mapped responder (slave).
interface bus_responder_timer_if #(
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned DATA_W = 32;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req,
      output we,
      output addr,
      output wdata,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  we,
      input  addr,
      input  wdata,
      output ack,
      output rdata
   );
endinterface

// File: rtl/bus_responder_timer.sv
// Memory-mapped bus responder with a 32-bit timer/compare peripheral.
// A 16-byte window at BASE_ADDR holds CTRL, CMP, COUNT and STATUS; every
// access is acknowledged after WAIT_CYCLES wait states, hit or miss.
// Optional macro BUS_RESP_ERR_EN: miss reads return 32'hDEAD_BEEF and any
// miss sets the sticky STATUS[1] error flag (write-1-to-clear).
module bus_responder_timer #(
   parameter int unsigned       ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h0000_FF00),
   parameter int unsigned       WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   bus_responder_timer_if.slave bus,
   output logic                 irq
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned WCNT_W = 4;
   localparam int unsigned IDX_W  = 2;

   // FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Register index, taken from addr[3:2]
   localparam logic [IDX_W-1:0] REG_CTRL   = 2'd0;
   localparam logic [IDX_W-1:0] REG_CMP    = 2'd1;
   localparam logic [IDX_W-1:0] REG_COUNT  = 2'd2;
   localparam logic [IDX_W-1:0] REG_STATUS = 2'd3;

`ifdef BUS_RESP_ERR_EN
   localparam logic [DATA_W-1:0] MISS_RDATA = 32'hDEAD_BEEF;
`else
   localparam logic [DATA_W-1:0] MISS_RDATA = 32'h0000_0000;
`endif

   // FSM and wait-state counter
   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [WCNT_W-1:0] wcnt;
   logic [WCNT_W-1:0] wcnt_nxt;

   // Transaction captured in IDLE
   logic              lat_we;
   logic              lat_hit;
   logic [IDX_W-1:0]  lat_idx;
   logic [DATA_W-1:0] lat_wdata;

   // Peripheral registers
   logic [1:0]        ctrl;
   logic [DATA_W-1:0] cmp;
   logic [DATA_W-1:0] count;
   logic              match;
   logic              err;

   // Decode and datapath helpers
   logic              hit_c;
   logic              sel_hit_c;
   logic              sel_we_c;
   logic [IDX_W-1:0]  sel_idx_c;
   logic [DATA_W-1:0] rd_val_c;
   logic              enter_resp_c;
   logic              commit_c;
   logic              wr_ctrl_c;
   logic              wr_cmp_c;
   logic              wr_count_c;
   logic              wr_status_c;
   logic              count_en_c;
   logic              match_set_c;

   // Byte-lane bits of the address carry no meaning for word registers
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^bus.addr[1:0];

   // Window decode on the live bus address
   assign hit_c = (bus.addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);

   // State and wait-counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   // Next-state logic: req is only looked at in IDLE
   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      case (state)
         ST_IDLE: begin
            if (bus.req) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = ST_RESP;
               end else begin
                  state_nxt = ST_WAIT;
                  wcnt_nxt  = WCNT_W'(WAIT_CYCLES);
               end
            end
         end
         ST_WAIT: begin
            if (wcnt <= WCNT_W'(1)) begin
               state_nxt = ST_RESP;
               wcnt_nxt  = '0;
            end else begin
               wcnt_nxt = wcnt - WCNT_W'(1);
            end
         end
         ST_RESP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            wcnt_nxt  = '0;
         end
      endcase
   end

   // Capture the request so the initiator may drop req early
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_we    <= 1'b0;
         lat_hit   <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
      end else if ((state == ST_IDLE) && bus.req) begin
         lat_we    <= bus.we;
         lat_hit   <= hit_c;
         lat_idx   <= bus.addr[3:2];
         lat_wdata <= bus.wdata;
      end
   end

   // With zero wait states RESP is entered on the capture edge, so use the live bus there
   always_comb begin
      sel_hit_c = lat_hit;
      sel_we_c  = lat_we;
      sel_idx_c = lat_idx;
      if (state == ST_IDLE) begin
         sel_hit_c = hit_c;
         sel_we_c  = bus.we;
         sel_idx_c = bus.addr[3:2];
      end
   end

   // Read mux over the register file
   always_comb begin
      rd_val_c = MISS_RDATA;
      if (sel_hit_c) begin
         case (sel_idx_c)
            REG_CTRL:   rd_val_c = {30'd0, ctrl};
            REG_CMP:    rd_val_c = cmp;
            REG_COUNT:  rd_val_c = count;
            REG_STATUS: rd_val_c = {30'd0, err, match};
            default:    rd_val_c = MISS_RDATA;
         endcase
      end
   end

   assign enter_resp_c = (state_nxt == ST_RESP);

   // Ack pulse and read data, both registered on the edge entering RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ack   <= 1'b0;
         bus.rdata <= '0;
      end else begin
         bus.ack <= enter_resp_c;
         if (enter_resp_c && !sel_we_c) begin
            bus.rdata <= rd_val_c;
         end
      end
   end

   // Writes commit on the edge leaving RESP
   assign commit_c    = (state == ST_RESP);
   assign wr_ctrl_c   = commit_c && lat_we && lat_hit && (lat_idx == REG_CTRL);
   assign wr_cmp_c    = commit_c && lat_we && lat_hit && (lat_idx == REG_CMP);
   assign wr_count_c  = commit_c && lat_we && lat_hit && (lat_idx == REG_COUNT);
   assign wr_status_c = commit_c && lat_we && lat_hit && (lat_idx == REG_STATUS);

   assign count_en_c  = ctrl[0];
   assign match_set_c = count_en_c && (count == cmp);

   // Control and compare registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl <= '0;
         cmp  <= '0;
      end else begin
         if (wr_ctrl_c) begin
            ctrl <= lat_wdata[1:0];
         end
         if (wr_cmp_c) begin
            cmp <= lat_wdata;
         end
      end
   end

   // Free-running counter; a bus write wins over the increment
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (wr_count_c) begin
         count <= lat_wdata;
      end else if (count_en_c) begin
         count <= count + DATA_W'(1);
      end
   end

   // Sticky match flag; a hardware set wins over a W1C
   always_ff @(posedge clk) begin
      if (rst) begin
         match <= 1'b0;
      end else if (match_set_c) begin
         match <= 1'b1;
      end else if (wr_status_c && lat_wdata[0]) begin
         match <= 1'b0;
      end
   end

   // Sticky miss-error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
`ifdef BUS_RESP_ERR_EN
      end else if (commit_c && !lat_hit) begin
         err <= 1'b1;
      end else if (wr_status_c && lat_wdata[1]) begin
         err <= 1'b0;
`else
      end else begin
         err <= 1'b0;
`endif
      end
   end

   // Level interrupt straight from registers
   assign irq = match && ctrl[1];

endmodule
